// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive-side controller.
package uart_pkg;

    // Idle-timeout FSM states
    typedef enum logic [1:0] {
        QUIET  = 2'd0,
        ACTIVE = 2'd1,
        FIRE   = 2'd2
    } timeout_state_t;

    // One received character
    typedef logic [7:0] byte_t;

    // Saturation point of the receiver error counter
    localparam int ERR_MAX = 255;

endpackage

// File: rtl/uart_fifo.sv
// Show-ahead byte FIFO: Depth entries, wrap-around pointers, separate fill count.
// Push into a full FIFO succeeds only when a pop happens in the same cycle;
// otherwise the byte is dropped and drop_o flags it. flush_i wins over push/pop.
module uart_fifo
    import uart_pkg::*;
#(
    parameter int Depth = 8
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  logic [7:0]             data_i,
    output logic [7:0]             data_o,
    output logic                   valid_o,
    output logic [$clog2(Depth):0] fill_o,
    output logic                   drop_o
);
    localparam int AW = $clog2(Depth);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_FILL = CW'(Depth);

    byte_t         mem_q [Depth];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] fill_q, fill_d;
    logic          empty, full, do_push, do_pop;

    assign empty   = (fill_q == '0);
    assign full    = (fill_q == FULL_FILL);
    assign do_pop  = pop_i && !empty && !flush_i;
    assign do_push = push_i && !flush_i && (!full || do_pop);
    assign drop_o  = push_i && !flush_i && full && !do_pop;

    assign data_o  = mem_q[rd_ptr_q];
    assign valid_o = !empty;
    assign fill_o  = fill_q;

    // Next pointer and fill values; flush returns everything to zero
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        fill_d   = fill_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            fill_d   = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
            if (do_push && !do_pop)      fill_d = fill_q + CW'(1);
            else if (!do_push && do_pop) fill_d = fill_q - CW'(1);
        end
    end

    // Pointer and fill registers
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            fill_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            fill_q   <= fill_d;
        end
    end

    // Storage array; cleared on reset so the head reads zero out of reset
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            for (int i = 0; i < Depth; i++) mem_q[i] <= '0;
        end else if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive-side controller: buffers receiver bytes in uart_fifo, tracks
// overrun and a saturating error count, and optionally raises a one-cycle
// idleTimeout pulse after IdleBits idle bit-times.
// Optional feature macro: UART_RX_CTRL_TIMEOUT_EN (timeout FSM and counter).
// Handshake: a byte transfers on every clk edge where outValid && outReady.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int Depth      = 8,
    parameter int Oversample = 16,
    parameter int IdleBits   = 20
) (
    input  logic                   clk,
    input  logic                   nReset,
    input  logic [7:0]             rxData,
    input  logic                   rxDone,
    input  logic                   rxErr,
    output logic [7:0]             outData,
    output logic                   outValid,
    input  logic                   outReady,
    output logic [$clog2(Depth):0] fill,
    output logic                   overrun,
    output logic [7:0]             errCount,
    output logic                   idleTimeout,
    input  logic                   clr,
    input  logic                   flush
);
    if (Depth < 2 || (Depth & (Depth - 1)) != 0 || IdleBits < 1 || Oversample < 1) begin : g_param_check
        $error("uart_rx_ctrl: Depth must be a power of two >= 2, IdleBits and Oversample >= 1");
    end

    logic       push, pop, drop;
    logic       overrun_q, overrun_d;
    logic [7:0] err_cnt_q, err_cnt_d;

    // A byte flagged with rxErr is discarded and only counted as an error
    assign push = rxDone && !rxErr;
    assign pop  = outValid && outReady;

    uart_fifo #(.Depth(Depth)) u_fifo (
        .clk     (clk),
        .nReset  (nReset),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (flush),
        .data_i  (rxData),
        .data_o  (outData),
        .valid_o (outValid),
        .fill_o  (fill),
        .drop_o  (drop)
    );

    // Next sticky overrun and saturating error count; clr has priority
    always_comb begin
        overrun_d = overrun_q;
        err_cnt_d = err_cnt_q;
        if (clr) begin
            overrun_d = 1'b0;
            err_cnt_d = '0;
        end else begin
            if (drop) overrun_d = 1'b1;
            if (rxErr && err_cnt_q != 8'(ERR_MAX)) err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    // Status registers
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            overrun_q <= 1'b0;
            err_cnt_q <= '0;
        end else begin
            overrun_q <= overrun_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign overrun  = overrun_q;
    assign errCount = err_cnt_q;

`ifdef UART_RX_CTRL_TIMEOUT_EN
    localparam int IDLE_CYCLES = IdleBits * Oversample;
    localparam int TW          = $clog2(IDLE_CYCLES + 1);
    localparam logic [TW-1:0] RELOAD = TW'(IDLE_CYCLES - 1);

    timeout_state_t state_q;
    logic [TW-1:0]  cnt_q;
    logic           idle_q;

    // Idle-timeout FSM: arms on a received byte, counts down, pulses once
    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            state_q <= QUIET;
            cnt_q   <= '0;
            idle_q  <= 1'b0;
        end else if (clr) begin
            state_q <= QUIET;
            cnt_q   <= '0;
            idle_q  <= 1'b0;
        end else begin
            idle_q <= 1'b0;
            case (state_q)
                QUIET: begin
                    if (push) begin
                        state_q <= ACTIVE;
                        cnt_q   <= RELOAD;
                    end
                end
                ACTIVE: begin
                    if (rxDone || rxErr) begin
                        cnt_q <= RELOAD;
                    end else if (cnt_q == '0) begin
                        state_q <= FIRE;
                        idle_q  <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q - TW'(1);
                    end
                end
                FIRE: begin
                    if (push) begin
                        state_q <= ACTIVE;
                        cnt_q   <= RELOAD;
                    end else begin
                        state_q <= QUIET;
                    end
                end
                default: state_q <= QUIET;
            endcase
        end
    end

    assign idleTimeout = idle_q;
`else
    assign idleTimeout = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl (Depth=8, Oversample=16, IdleBits=2).
module tb_uart_rx_ctrl;
    logic       clk;
    logic       nReset;
    logic [7:0] rxData;
    logic       rxDone;
    logic       rxErr;
    logic [7:0] outData;
    logic       outValid;
    logic       outReady;
    logic [3:0] fill;
    logic       overrun;
    logic [7:0] errCount;
    logic       idleTimeout;
    logic       clr;
    logic       flush;

    int n_checks = 0;
    int n_errors = 0;

    uart_rx_ctrl #(.Depth(8), .Oversample(16), .IdleBits(2)) dut (
        .clk         (clk),
        .nReset      (nReset),
        .rxData      (rxData),
        .rxDone      (rxDone),
        .rxErr       (rxErr),
        .outData     (outData),
        .outValid    (outValid),
        .outReady    (outReady),
        .fill        (fill),
        .overrun     (overrun),
        .errCount    (errCount),
        .idleTimeout (idleTimeout),
        .clr         (clr),
        .flush       (flush)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        assert (obs === exp_v) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
        end
    endtask

    task automatic push_byte(input logic [7:0] d);
        rxData = d;
        rxDone = 1'b1;
        step();
        rxDone = 1'b0;
    endtask

    initial begin : stimulus
        logic [7:0] exp_bytes [8];
        logic       seen;

        nReset = 1'b0; rxData = '0; rxDone = 1'b0; rxErr = 1'b0;
        outReady = 1'b0; clr = 1'b0; flush = 1'b0;

        // Reset values
        step(); step();
        check("rst_outValid", outValid, 0);
        check("rst_fill", fill, 0);
        check("rst_overrun", overrun, 0);
        check("rst_errCount", errCount, 0);
        check("rst_idle", idleTimeout, 0);
        check("rst_outData", outData, 0);
        nReset = 1'b1;
        step();

        // Single byte: visible next cycle, popped when outReady rises
        push_byte(8'hA5);
        check("a5_valid", outValid, 1);
        check("a5_data", outData, 8'hA5);
        check("a5_fill", fill, 1);
        outReady = 1'b1;
        step();
        check("a5_pop_valid", outValid, 0);
        check("a5_pop_fill", fill, 0);
        outReady = 1'b0;

        // Nine pushes into eight entries: last byte dropped, overrun set
        for (int i = 0; i < 9; i++) push_byte(8'(i));
        check("ovf_fill", fill, 8);
        check("ovf_overrun", overrun, 1);
        outReady = 1'b1;
        for (int i = 0; i < 8; i++) begin
            check("ovf_drain_valid", outValid, 1);
            check("ovf_drain_data", outData, 8'(i));
            step();
        end
        check("ovf_empty_valid", outValid, 0);
        check("ovf_empty_fill", fill, 0);
        check("ovf_sticky", overrun, 1);
        outReady = 1'b0;
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("clr_overrun", overrun, 0);

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 8; i++) push_byte(8'h10 + 8'(i));
        check("full_fill", fill, 8);
        rxData = 8'h55; rxDone = 1'b1; outReady = 1'b1;
        step();
        rxDone = 1'b0;
        check("pushpop_fill", fill, 8);
        check("pushpop_overrun", overrun, 0);
        exp_bytes = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
        for (int i = 0; i < 8; i++) begin
            check("pushpop_data", outData, exp_bytes[i]);
            step();
        end
        check("pushpop_empty", fill, 0);

        // Pop on empty ignored; push with outReady high has no fall-through
        step();
        check("empty_pop_fill", fill, 0);
        rxData = 8'h3C; rxDone = 1'b1;
        check("nofall_valid", outValid, 0);
        step();
        rxDone = 1'b0;
        check("nofall_next_valid", outValid, 1);
        check("nofall_next_data", outData, 8'h3C);
        check("nofall_next_fill", fill, 1);
        step();
        check("nofall_pop_fill", fill, 0);
        outReady = 1'b0;

        // Flush beats a coincident push and does not set overrun
        push_byte(8'h01);
        push_byte(8'h02);
        check("flush_pre_fill", fill, 2);
        flush = 1'b1; rxData = 8'h99; rxDone = 1'b1;
        step();
        flush = 1'b0; rxDone = 1'b0;
        check("flush_fill", fill, 0);
        check("flush_valid", outValid, 0);
        check("flush_overrun", overrun, 0);

        // 300 error pulses, one coincident with a byte that must be discarded
        for (int i = 0; i < 300; i++) begin
            rxErr = 1'b1;
            rxDone = (i == 100);
            rxData = 8'h33;
            step();
            if (i == 9) check("err_count10", errCount, 10);
        end
        rxErr = 1'b0; rxDone = 1'b0;
        check("err_sat", errCount, 255);
        check("err_byte_fill", fill, 0);
        check("err_byte_valid", outValid, 0);
        rxErr = 1'b1; clr = 1'b1;
        step();
        rxErr = 1'b0; clr = 1'b0;
        check("err_clr", errCount, 0);

        // Idle timeout
        outReady = 1'b1;
        push_byte(8'h77);
`ifdef UART_RX_CTRL_TIMEOUT_EN
        seen = 1'b0;
        repeat (31) begin step(); if (idleTimeout) seen = 1'b1; end
        check("to_early", seen, 0);
        step();
        check("to_pulse", idleTimeout, 1);
        step();
        check("to_one_cycle", idleTimeout, 0);
        push_byte(8'h78);
        seen = 1'b0;
        repeat (19) begin step(); if (idleTimeout) seen = 1'b1; end
        push_byte(8'h79);
        repeat (31) begin step(); if (idleTimeout) seen = 1'b1; end
        check("to_reload_early", seen, 0);
        step();
        check("to_reload_pulse", idleTimeout, 1);
        step();
        check("to_reload_one_cycle", idleTimeout, 0);
`else
        seen = 1'b0;
        repeat (40) begin step(); if (idleTimeout) seen = 1'b1; end
        check("to_disabled", seen, 0);
`endif
        outReady = 1'b0;
        step();

        // Asynchronous reset mid-burst
        for (int i = 0; i < 9; i++) push_byte(8'hC0 + 8'(i));
        outReady = 1'b1;
        step(); step(); step();
        outReady = 1'b0;
        check("mid_fill", fill, 5);
        check("mid_overrun", overrun, 1);
        #2;
        nReset = 1'b0;
        #1;
        check("arst_valid", outValid, 0);
        check("arst_fill", fill, 0);
        check("arst_overrun", overrun, 0);
        check("arst_errCount", errCount, 0);
        check("arst_idle", idleTimeout, 0);
        check("arst_outData", outData, 0);
        step();
        nReset = 1'b1;
        step();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
